complex_mxv_row_feeder: RTL

COMPLEX_MXV_ROW_FEEDER -- requirements
Module: complex_mxv_row_feeder

---
 rtl/complex_pkg.sv | 20 ++
 rtl/complex_lane_mask.sv | 24 ++
 rtl/complex_mxv_row_feeder.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/complex_pkg.sv
// Shared definitions for the complex matrix-vector row feeder:
// default element geometry, the feeder state encoding and the drain-beat count.
package complex_pkg;

   localparam int DEFAULT_ELEMENT_WIDTH = 64;
   localparam int DEFAULT_NO_OF_UNITS   = 8;

   // Number of all-zero drain beats appended after every matrix row.
   localparam int FLUSH_BEATS = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_PRESENT,
      ST_FLUSH,
      ST_NEXT,
      ST_FIN
   } feeder_state_e;

endpackage

// File: rtl/complex_lane_mask.sv
// Tail lane masking: lanes at index >= lane_cnt_i are forced to zero,
// lanes below it pass through. Purely combinational; lane 0 is the LSB slice.
module complex_lane_mask
   import complex_pkg::*;
#(
   parameter int ELEMENT_WIDTH = DEFAULT_ELEMENT_WIDTH,
   parameter int NO_OF_UNITS   = DEFAULT_NO_OF_UNITS,
   parameter int CNT_WIDTH     = $clog2(NO_OF_UNITS + 1)
) (
   input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] data_i,
   input  logic [CNT_WIDTH-1:0]                 lane_cnt_i,
   output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] data_o
);

   genvar gi;
   generate
      for (gi = 0; gi < NO_OF_UNITS; gi++) begin : g_lane
         assign data_o[gi*ELEMENT_WIDTH +: ELEMENT_WIDTH] =
            (CNT_WIDTH'(gi) < lane_cnt_i) ? data_i[gi*ELEMENT_WIDTH +: ELEMENT_WIDTH]
                                          : '0;
      end
   endgenerate

endmodule

// File: rtl/complex_mxv_row_feeder.sv
// Complex matrix-vector row feeder. Streams each matrix row, beat by beat,
// together with the matching vector beat to a dot-product unit, then appends
// FLUSH_BEATS zero drain beats per row. One beat every 2 cycles at best
// (READ then PRESENT).
// Optional feature macro: COMPLEX_FEEDER_ZERO_PAD_EN -- zero the unused tail
// lanes of the last data beat of a row when total is not a multiple of
// NO_OF_UNITS. Without it, memory data passes through unmodified.
module complex_mxv_row_feeder
   import complex_pkg::*;
#(
   parameter int ELEMENT_WIDTH = DEFAULT_ELEMENT_WIDTH,
   parameter int NO_OF_UNITS   = DEFAULT_NO_OF_UNITS,
   parameter int ADDR_WIDTH    = 10
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic [31:0]                          total,
   input  logic [15:0]                          num_rows,
   input  logic [ADDR_WIDTH-1:0]                mat_base,
   input  logic [ADDR_WIDTH-1:0]                vec_base,
   output logic                                 mat_re,
   output logic                                 vec_re,
   output logic [ADDR_WIDTH-1:0]                mat_addr,
   output logic [ADDR_WIDTH-1:0]                vec_addr,
   input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] mat_rdata,
   input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] vec_rdata,
   output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] row_data,
   output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] vec_data,
   output logic                                 data_valid,
   input  logic                                 data_ready,
   output logic                                 flush,
   output logic                                 row_done,
   output logic                                 busy,
   output logic                                 done
);

   localparam int DW  = ELEMENT_WIDTH * NO_OF_UNITS;
   localparam int LCW = $clog2(NO_OF_UNITS + 1);
   localparam int FCW = (FLUSH_BEATS > 1) ? $clog2(FLUSH_BEATS) : 1;
   localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_BEATS - 1);
   localparam logic [LCW-1:0] FULL_LANES = LCW'(NO_OF_UNITS);

`ifdef COMPLEX_FEEDER_ZERO_PAD_EN
   localparam bit ZERO_PAD = 1'b1;
`else
   localparam bit ZERO_PAD = 1'b0;
`endif

   feeder_state_e         state_q, state_d;
   logic [15:0]           row_q, row_d;
   logic [15:0]           nrows_q, nrows_d;
   logic [31:0]           beat_q, beat_d;
   logic [31:0]           beats_q, beats_d;
   logic [LCW-1:0]        tail_q, tail_d;
   logic [ADDR_WIDTH-1:0] vbase_q, vbase_d;
   logic [ADDR_WIDTH-1:0] mat_addr_q, mat_addr_d;
   logic [ADDR_WIDTH-1:0] vec_addr_q, vec_addr_d;
   logic [FCW-1:0]        fcnt_q, fcnt_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  first_q;
   logic [DW-1:0]         mat_hold_q, vec_hold_q;

   // Row geometry derived from total at start: beats per row and the number
   // of populated lanes in the last beat (a full beat when total divides evenly).
   logic [31:0]    tail_rem;
   logic [31:0]    beats_calc;
   logic [LCW-1:0] tail_calc;
   assign tail_rem   = total % 32'(NO_OF_UNITS);
   assign beats_calc = (total / 32'(NO_OF_UNITS)) + {31'd0, (tail_rem != 32'd0)};
   assign tail_calc  = (tail_rem == 32'd0) ? FULL_LANES : LCW'(tail_rem);

   logic last_beat;
   assign last_beat = (beat_q == beats_q - 32'd1);

   // Next-state and counter update logic.
   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      nrows_d    = nrows_q;
      beat_d     = beat_q;
      beats_d    = beats_q;
      tail_d     = tail_q;
      vbase_d    = vbase_q;
      mat_addr_d = mat_addr_q;
      vec_addr_d = vec_addr_q;
      fcnt_d     = fcnt_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               row_d      = '0;
               beat_d     = '0;
               fcnt_d     = '0;
               nrows_d    = num_rows;
               beats_d    = beats_calc;
               tail_d     = tail_calc;
               vbase_d    = vec_base;
               mat_addr_d = mat_base;
               vec_addr_d = vec_base;
               busy_d     = 1'b1;
               state_d    = (total == 32'd0 || num_rows == 16'd0) ? ST_FIN : ST_READ;
            end
         end
         ST_READ: begin
            state_d = ST_PRESENT;
         end
         ST_PRESENT: begin
            if (data_ready) begin
               mat_addr_d = mat_addr_q + 1'b1;
               beat_d     = beat_q + 32'd1;
               if (!last_beat) begin
                  vec_addr_d = vec_addr_q + 1'b1;
                  state_d    = ST_READ;
               end else begin
                  vec_addr_d = vbase_q;
                  fcnt_d     = '0;
                  state_d    = ST_FLUSH;
               end
            end
         end
         ST_FLUSH: begin
            if (data_ready) begin
               if (fcnt_q == FLUSH_LAST) begin
                  state_d = ST_NEXT;
               end else begin
                  fcnt_d = fcnt_q + 1'b1;
               end
            end
         end
         ST_NEXT: begin
            if (({1'b0, row_q} + 17'd1) < {1'b0, nrows_q}) begin
               row_d   = row_q + 16'd1;
               beat_d  = '0;
               state_d = ST_READ;
            end else begin
               state_d = ST_FIN;
            end
         end
         ST_FIN: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         row_q      <= '0;
         nrows_q    <= '0;
         beat_q     <= '0;
         beats_q    <= '0;
         tail_q     <= '0;
         vbase_q    <= '0;
         mat_addr_q <= '0;
         vec_addr_q <= '0;
         fcnt_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         nrows_q    <= nrows_d;
         beat_q     <= beat_d;
         beats_q    <= beats_d;
         tail_q     <= tail_d;
         vbase_q    <= vbase_d;
         mat_addr_q <= mat_addr_d;
         vec_addr_q <= vec_addr_d;
         fcnt_q     <= fcnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Read data is only guaranteed in the cycle after the read enable, so it is
   // captured then and replayed from the hold registers while the consumer stalls.
   always_ff @(posedge clk) begin
      if (reset) begin
         first_q    <= 1'b0;
         mat_hold_q <= '0;
         vec_hold_q <= '0;
      end else begin
         first_q <= (state_q == ST_READ);
         if (state_q == ST_PRESENT && first_q) begin
            mat_hold_q <= mat_rdata;
            vec_hold_q <= vec_rdata;
         end
      end
   end

   logic [DW-1:0]  mat_raw, vec_raw, mat_masked, vec_masked;
   logic [LCW-1:0] lane_cnt;
   assign mat_raw  = first_q ? mat_rdata : mat_hold_q;
   assign vec_raw  = first_q ? vec_rdata : vec_hold_q;
   assign lane_cnt = (ZERO_PAD && last_beat) ? tail_q : FULL_LANES;

   complex_lane_mask #(
      .ELEMENT_WIDTH (ELEMENT_WIDTH),
      .NO_OF_UNITS   (NO_OF_UNITS),
      .CNT_WIDTH     (LCW)
   ) u_mat_mask (
      .data_i     (mat_raw),
      .lane_cnt_i (lane_cnt),
      .data_o     (mat_masked)
   );

   complex_lane_mask #(
      .ELEMENT_WIDTH (ELEMENT_WIDTH),
      .NO_OF_UNITS   (NO_OF_UNITS),
      .CNT_WIDTH     (LCW)
   ) u_vec_mask (
      .data_i     (vec_raw),
      .lane_cnt_i (lane_cnt),
      .data_o     (vec_masked)
   );

   assign mat_re     = (state_q == ST_READ);
   assign vec_re     = (state_q == ST_READ);
   assign mat_addr   = mat_addr_q;
   assign vec_addr   = vec_addr_q;
   assign data_valid = (state_q == ST_PRESENT) || (state_q == ST_FLUSH);
   assign flush      = (state_q == ST_FLUSH);
   assign row_data   = (state_q == ST_PRESENT) ? mat_masked : '0;
   assign vec_data   = (state_q == ST_PRESENT) ? vec_masked : '0;
   assign row_done   = (state_q == ST_NEXT);
   assign busy       = busy_q;
   assign done       = done_q;

endmodule
